rr_arbiter_8: RTL and testbench

Eight-way round-robin arbiter producing a registered one-hot grant vector for the 8-to-3 encoder stage that follows it. Requesters raise `req` bits. The arbiter grants exactly one of them and holds that grant until the owner releases. Priority rotates fairly so no requester starves. Its `grant` output is always zero or exactly one-hot, which is the only input class the downstream encoder decodes.

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_arbiter_8.sv | 154 +++++++++++++++
 tb/tb_rr_arbiter_8.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Exports RR_N, RR_IDX_W, RR_TIMEOUT and the FSM state type rr_state_t.
package rr_arb_pkg;

  localparam int RR_N       = 8;
  localparam int RR_IDX_W   = 3;
  localparam int RR_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first eligible request at or after ptr.
// Ports: req/mask (N-bit, masked bits ineligible), ptr (start index) ->
//   pick (one-hot or zero), pick_idx (winner index), any (a winner exists).
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [RR_N-1:0]     req,
  input  logic [RR_N-1:0]     mask,
  input  logic [RR_IDX_W-1:0] ptr,
  output logic [RR_N-1:0]     pick,
  output logic [RR_IDX_W-1:0] pick_idx,
  output logic                any
);

  logic [RR_N-1:0]     elig;
  logic [RR_IDX_W-1:0] idx;

  always_comb begin
    elig     = req & ~mask;
    idx      = '0;
    pick_idx = '0;
    any      = 1'b0;
    // The 3-bit add wraps 7 -> 0, giving the rotated scan order.
    for (int k = 0; k < RR_N; k++) begin
      idx = ptr + RR_IDX_W'(k);
      if (!any && elig[idx]) begin
        any      = 1'b1;
        pick_idx = idx;
      end
    end
    pick = any ? (RR_N'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant that is
// held until the owner releases (done pulse or its req dropping).
// Ports: clk, rst (async, active-high), req[7:0], done ->
//   grant[7:0] (one-hot or zero), grant_valid (OR of grant), timeout.
// Optional macro RR_ARBITER_TIMEOUT_EN adds a hold counter that forces a
// release after TIMEOUT cycles and pulses timeout; otherwise timeout = 0.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int N       = RR_N,
  parameter int TIMEOUT = RR_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  if (N != RR_N) begin : g_bad_n
    $error("rr_arbiter_8: N must be 8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_to
    $error("rr_arbiter_8: TIMEOUT out of range 2..65535");
  end

  rr_state_t           state_q, state_d;
  logic [RR_IDX_W-1:0] ptr_q, ptr_d;
  logic [RR_IDX_W-1:0] owner_q, owner_d;
  logic [RR_N-1:0]     grant_q, grant_d;
  logic                gv_q;

  logic [RR_N-1:0]     pick_mask;
  logic [RR_IDX_W-1:0] pick_ptr;
  logic [RR_N-1:0]     pick;
  logic [RR_IDX_W-1:0] pick_idx;
  logic                pick_any;

  logic                owner_req;
  logic                norm_rel;
  logic                force_rel;
  logic                rel;
  logic                new_grant;

  // While busy, the picker already runs from owner+1 with the owner masked,
  // so a release can hand over on the same edge.
  always_comb begin
    pick_ptr  = ptr_q;
    pick_mask = '0;
    if (state_q == BUSY) begin
      pick_ptr  = owner_q + 1'b1;
      pick_mask = grant_q;
    end
  end

  rr_pick u_pick (
    .req      (req),
    .mask     (pick_mask),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign owner_req = req[owner_q];
  assign norm_rel  = done || !owner_req;
  assign rel       = norm_rel || force_rel;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    new_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d   = pick;
          owner_d   = pick_idx;
          state_d   = BUSY;
          new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d = owner_q + 1'b1;
          if (pick_any) begin
            grant_d   = pick;
            owner_d   = pick_idx;
            new_grant = 1'b1;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      gv_q    <= |grant_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic        to_q;

  assign force_rel = (state_q == BUSY) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      // A release by done/req-drop on the same edge is not a timeout.
      to_q <= force_rel && !norm_rel;
      if (new_grant) begin
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign timeout = to_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = gv_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 with hand-computed expectations.
// Covers reset, rotation, pointer order, release to idle, async reset, hold.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int errs;
  int checks;

  rr_arbiter_8 #(
    .N       (8),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g;
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    req    = 8'hFF;
    done   = 1'b0;

    // Reset held with all requesting
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h00);
    chk("rst_gv", 32'(grant_valid), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);
    rst = 1'b0;
    step();
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_gv", 32'(grant_valid), 32'h1);

    // Full rotation, done every third cycle, no gaps
    for (int i = 1; i <= 8; i++) begin
      exp_g = 8'h01 << ((i - 1) % 8);
      step();
      chk("rot_hold", 32'(grant), 32'(exp_g));
      step();
      chk("rot_hold", 32'(grant), 32'(exp_g));
      done = 1'b1;
      step();
      done = 1'b0;
      exp_g = 8'h01 << (i % 8);
      chk("rot_next", 32'(grant), 32'(exp_g));
      chk("rot_gv", 32'(grant_valid), 32'h1);
    end

    // Advance to owner 2, then drop all: ptr becomes 3
    done = 1'b1;
    step();
    step();
    done = 1'b0;
    chk("own2", 32'(grant), 32'h04);
    req = 8'h00;
    step();
    chk("idle_grant", 32'(grant), 32'h00);
    chk("idle_gv", 32'(grant_valid), 32'h0);

    // ptr = 3 with req 0010_0100: index 5 first, then 2
    req = 8'b0010_0100;
    step();
    chk("ptr3_pick", 32'(grant), 32'h20);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ptr3_next", 32'(grant), 32'h04);

    // Release to idle (ptr 3), then grant 0x08 and drop it
    req = 8'h00;
    step();
    req = 8'h08;
    step();
    chk("g08", 32'(grant), 32'h08);
    req = 8'h00;
    step();
    chk("drop_grant", 32'(grant), 32'h00);
    chk("drop_gv", 32'(grant_valid), 32'h0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done", 32'(grant), 32'h00);
    chk("idle_done_gv", 32'(grant_valid), 32'h0);

    // ptr is 4: grant 0x10, then async reset
    req = 8'h10;
    step();
    chk("g10", 32'(grant), 32'h10);
    rst = 1'b1;
    #1;
    chk("async_rst", 32'(grant), 32'h00);
    chk("async_gv", 32'(grant_valid), 32'h0);
    req = 8'h90;
    step();
    chk("rst_hold", 32'(grant), 32'h00);
    rst = 1'b0;
    step();
    chk("post_rst", 32'(grant), 32'h10);

    // done with owner's req drop together: a single release
    req  = 8'h80;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dual_rel", 32'(grant), 32'h80);
    step();
    chk("dual_hold", 32'(grant), 32'h80);

    // Release owner 7 -> ptr 0, then hold test with req 0x03
    req = 8'h00;
    step();
    chk("idle2", 32'(grant), 32'h00);
    req = 8'h03;
    step();
    chk("hold_first", 32'(grant), 32'h01);
`ifdef RR_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold", 32'(grant), 32'h01);
      chk("to_low", 32'(timeout), 32'h0);
    end
    step();
    chk("to_switch", 32'(grant), 32'h02);
    chk("to_pulse", 32'(timeout), 32'h1);
    step();
    chk("to_pulse_end", 32'(timeout), 32'h0);
    chk("to_after", 32'(grant), 32'h02);
`else
    for (int i = 0; i < 110; i++) begin
      step();
      chk("long_hold", 32'(grant), 32'h01);
      chk("no_to", 32'(timeout), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
